// File: rtl/regfile_dump_tx.sv
// Register-file debug dump transmitter: snapshots the packed debug bus on Start and
// streams header, register bytes (high byte first) and an XOR checksum over valid/ready.
module regfile_dump_tx #(
  parameter int          RegCount   = 8,
  parameter int          RegWidth   = 16,
  parameter logic [7:0]  HeaderByte = 8'hA5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [RegCount*RegWidth-1:0] i_debug_data,
  output logic [7:0]                   o_out_byte,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int SnapW    = RegCount * RegWidth;
  localparam int NumBytes = 2 * RegCount + 2;
  localparam int LastIdx  = NumBytes - 1;
  localparam int IdxW     = $clog2(NumBytes);
  localparam int DbW      = $clog2(2 * RegCount);
  localparam int OffW     = $clog2(SnapW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [SnapW-1:0] r_snapshot, w_snapshot_next;
  logic [IdxW-1:0]  r_idx, w_idx_next;
  logic [7:0]       r_csum, w_csum_next;
  logic [7:0]       r_out_byte, w_out_byte_next;
  logic             r_out_valid, w_out_valid_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;

  // The byte following index n (n = 0..2*RegCount-1) is data byte n. Data byte n
  // sits at bit offset 8*(n^1): even n is a register's high byte, odd n its low byte.
  logic [DbW-1:0]  w_data_num;
  logic [OffW-1:0] w_data_off;
  logic [7:0]      w_data_byte;
  logic            w_xfer;

  assign w_data_num  = r_idx[DbW-1:0];
  assign w_data_off  = {w_data_num ^ DbW'(1), 3'b000};
  assign w_data_byte = r_snapshot[w_data_off +: 8];
  assign w_xfer      = r_out_valid & i_out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_snapshot_next  = r_snapshot;
    w_idx_next       = r_idx;
    w_csum_next      = r_csum;
    w_out_byte_next  = r_out_byte;
    w_out_valid_next = r_out_valid;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;

    case (r_state)
      ST_SEND: begin
        if (w_xfer) begin
          if (r_idx == IdxW'(LastIdx)) begin
            w_state_next     = ST_DONE;
            w_out_byte_next  = 8'h00;
            w_out_valid_next = 1'b0;
            w_busy_next      = 1'b0;
            w_done_next      = 1'b1;
          end else begin
            w_idx_next = r_idx + IdxW'(1);
            if (r_idx != '0) begin
              w_csum_next = r_csum ^ r_out_byte;
            end
            // The checksum byte must include the data byte being accepted right now.
            if (r_idx == IdxW'(LastIdx - 1)) begin
              w_out_byte_next = r_csum ^ r_out_byte;
            end else begin
              w_out_byte_next = w_data_byte;
            end
          end
        end
      end

      default: begin
        // IDLE and DONE both accept a new request, so back-to-back dumps lose no cycle.
        w_state_next     = ST_IDLE;
        w_out_byte_next  = 8'h00;
        w_out_valid_next = 1'b0;
        w_busy_next      = 1'b0;
        if (i_start) begin
          w_state_next     = ST_SEND;
          w_snapshot_next  = i_debug_data;
          w_csum_next      = 8'h00;
          w_idx_next       = '0;
          w_out_byte_next  = HeaderByte;
          w_out_valid_next = 1'b1;
          w_busy_next      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_snapshot  <= '0;
      r_idx       <= '0;
      r_csum      <= 8'h00;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_snapshot  <= w_snapshot_next;
      r_idx       <= w_idx_next;
      r_csum      <= w_csum_next;
      r_out_byte  <= w_out_byte_next;
      r_out_valid <= w_out_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  assign o_out_byte  = r_out_byte;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: packet contents, stalls, snapshot freeze,
// ignored/back-to-back Start and asynchronous mid-packet reset.
module tb_regfile_dump_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] data;
  logic [7:0]   ob;
  logic         ov;
  logic         ready;
  logic         busy;
  logic         done;

  regfile_dump_tx dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_debug_data (data),
    .o_out_byte   (ob),
    .o_out_valid  (ov),
    .i_out_ready  (ready),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp1 [0:17];
  logic [7:0] got  [0:31];
  int         got_n;
  int         busy_cycles;
  int         stall_err;
  int         stalls_seen;
  logic       done_after, valid_after, busy_after;

  localparam logic [127:0] DATA1 = {16'h0001, 80'h0, 16'hABCD, 16'h1234};
  localparam logic [127:0] DATA3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DATA4 = 128'hDEAD_BEEF_0F0F_F0F0_1357_2468_55AA_C3C3;

  // Reference packet byte k for register bus d.
  function automatic logic [7:0] exp_byte(input logic [127:0] d, input int k);
    logic [7:0] x;
    int         r;
    if (k == 0) return 8'hA5;
    if (k == 17) begin
      x = 8'h00;
      for (int j = 0; j < 8; j++) x = x ^ d[16*j+8 +: 8] ^ d[16*j +: 8];
      return x;
    end
    r = (k - 1) / 2;
    if (((k - 1) % 2) == 0) return d[16*r+8 +: 8];
    return d[16*r +: 8];
  endfunction

  // Gathers one packet starting at the current negedge. mode 0: ready held high;
  // mode 1: ready toggling plus a 5-cycle stall at index 9; mode 2: ready high and
  // a stray Start pulse while index 4 is on the bus.
  task automatic collect(input int mode);
    int         cyc;
    int         stall_cnt;
    logic       pv, pr, r;
    logic [7:0] pb;
    cyc = 0; stall_cnt = 0; pv = 1'b0; pr = 1'b0; pb = 8'h00;
    got_n = 0; busy_cycles = 0; stall_err = 0; stalls_seen = 0;
    for (int k = 0; k < 32; k++) got[k] = 8'hXX;
    while (got_n < 18 && cyc < 300) begin
      if (busy) busy_cycles++;
      if (pv && !ov) stall_err++;
      if (pv && !pr && ob !== pb) stall_err++;
      r = 1'b1;
      start = 1'b0;
      if (mode == 1) begin
        if (got_n == 9 && stall_cnt < 5) begin
          r = 1'b0;
          stall_cnt++;
          stalls_seen++;
        end else begin
          r = (cyc % 2) == 0;
        end
      end else if (mode == 2) begin
        start = (got_n == 4);
      end
      ready = r;
      if (ov && r) begin
        got[got_n] = ob;
        got_n++;
      end
      pv = ov; pr = r; pb = ob;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    done_after  = done;
    valid_after = ov;
    busy_after  = busy;
    $display("packet: mode=%0d bytes=%0d busy_cycles=%0d done=%0b cycles=%0d",
             mode, got_n, busy_cycles, done_after, cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready = 1'b0; data = DATA3;
    repeat (3) @(negedge clk);
    total++; if (ov !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", ov); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (ob !== 8'h00)   begin bad++; $display("FAIL reset_byte got=%h want=00", ob); end
    rst = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", ov); end
    $display("reset: outputs idle");
  endtask

  task automatic test_basic;
    data = DATA1; ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", ov); end
    total++; if (ob !== 8'hA5) begin bad++; $display("FAIL basic_first got=%h want=a5", ob); end
    collect(0);
    total++; if (got_n !== 18) begin bad++; $display("FAIL basic_count got=%0d want=18", got_n); end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (got[k] !== exp1[k]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", k, got[k], exp1[k]); end
    end
    total++; if (busy_cycles !== 18) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=18", busy_cycles); end
    total++; if (done_after !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done_after); end
    total++; if (valid_after !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b want=0", valid_after); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy_after); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_stall;
    data = DATA1; ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(1);
    total++; if (got_n !== 18) begin bad++; $display("FAIL stall_count got=%0d want=18", got_n); end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (got[k] !== exp1[k]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", k, got[k], exp1[k]); end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_err); end
    total++; if (stalls_seen !== 5) begin bad++; $display("FAIL stall_len got=%0d want=5", stalls_seen); end
    total++; if (done_after !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", done_after); end
    @(negedge clk);
  endtask

  task automatic test_freeze;
    data = {128{1'b1}}; ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data = 128'h0;
    collect(0);
    total++; if (got_n !== 18) begin bad++; $display("FAIL freeze_count got=%0d want=18", got_n); end
    for (int k = 1; k < 17; k++) begin
      total++;
      if (got[k] !== 8'hFF) begin bad++; $display("FAIL freeze_byte%0d got=%h want=ff", k, got[k]); end
    end
    total++; if (got[17] !== 8'h00) begin bad++; $display("FAIL freeze_csum got=%h want=00", got[17]); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    data = DATA3; ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(2);
    total++; if (got_n !== 18) begin bad++; $display("FAIL ign_count got=%0d want=18", got_n); end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (got[k] !== exp_byte(DATA3, k)) begin bad++; $display("FAIL ign_byte%0d got=%h want=%h", k, got[k], exp_byte(DATA3, k)); end
    end
    total++; if (done_after !== 1'b1) begin bad++; $display("FAIL ign_done got=%b want=1", done_after); end
    @(negedge clk);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL ign_no_queue_valid got=%b want=0", ov); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_queue_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    data = DATA1; ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(0);
    total++; if (done_after !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done_after); end
    start = 1'b1;
    data = DATA4;
    @(negedge clk);
    start = 1'b0;
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", ov); end
    total++; if (ob !== 8'hA5) begin bad++; $display("FAIL b2b_header got=%h want=a5", ob); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    collect(0);
    total++; if (got_n !== 18) begin bad++; $display("FAIL b2b_count got=%0d want=18", got_n); end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (got[k] !== exp_byte(DATA4, k)) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", k, got[k], exp_byte(DATA4, k)); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    data = DATA1; ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL abort_pre_valid got=%b want=1", ov); end
    total++; if (ob !== exp1[10]) begin bad++; $display("FAIL abort_pre_byte got=%h want=%h", ob, exp1[10]); end
    #2 rst = 1'b1;
    #1;
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", ov); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (ob !== 8'h00) begin bad++; $display("FAIL abort_byte got=%h want=00", ob); end
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", done); end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(0);
    total++; if (got_n !== 18) begin bad++; $display("FAIL abort_count got=%0d want=18", got_n); end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (got[k] !== exp1[k]) begin bad++; $display("FAIL abort_byte%0d got=%h want=%h", k, got[k], exp1[k]); end
    end
    total++; if (done_after !== 1'b1) begin bad++; $display("FAIL abort_done got=%b want=1", done_after); end
    @(negedge clk);
  endtask

  initial begin
    exp1 = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h01, 8'h41};
    rst = 1'b1; start = 1'b0; ready = 1'b0; data = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_stall;
    test_freeze;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Debug transmitter that reads the CPU register file's packed debug bus (8 x 16-bit registers, R7 = flags) and streams a snapshot out as a byte-wide valid/ready packet.
- Sits between the register file's debug output and the byte-stream debug link (UART/host bridge).
- Packet: header, 16 data bytes, XOR checksum.
- Gives the bench and bring-up a cycle-consistent register dump without stalling the core.

Parameters:
- RegCount, 8, number of registers in the snapshot.
- RegWidth, 16, bits per register; must be 16 (two bytes per register).
- HeaderByte, 8'hA5, first byte of every packet.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a dump; sampled on rising Clk.
- DebugData  input  128  packed registers; register i at bits [16*i +: 16].
- OutByte  output  8  current packet byte.
- OutValid  output  1  OutByte is valid.
- OutReady  input  1  sink accepts the byte.
- Busy  output  1  a packet is in progress (snapshot held).
- Done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high.
- While Reset=1:
  - state = IDLE; OutByte = 0, OutValid = 0, Busy = 0, Done = 0.
  - Byte counter = 0, checksum = 0, snapshot = 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - On an edge with Start=1: capture DebugData into a 128-bit snapshot, clear the checksum, set byte index = 0, go to SEND.
  - After that edge: Busy = 1, OutValid = 1, OutByte = HeaderByte. Latency from Start to first valid byte is 1 cycle.
- SEND:
  - 18 bytes, index 0..17 (5-bit counter).
  - Index 0: HeaderByte.
  - Index 1..16: data bytes, register 0 first, high byte then low byte. Index 2r+1 = snapshot[16r+15:16r+8], index 2r+2 = snapshot[16r+7:16r].
  - Index 17: checksum = XOR of the 16 data bytes (header excluded).
- Handshake:
  - A byte transfers on a rising edge with OutValid=1 and OutReady=1; the index then increments.
  - While OutValid=1 and OutReady=0, OutByte and the index hold.
  - OutValid never drops mid-packet.
  - The checksum accumulates on each accepted data byte only.
- Checksum accepted (index 17 transfers): go to DONE. In that cycle OutValid = 0, Busy = 0, Done = 1.
- DONE: lasts one cycle, then returns to IDLE. A Start sampled at the DONE edge is honoured (same as IDLE) and the next packet begins.
- Start while in SEND is ignored, not queued.
- The snapshot is frozen for the whole packet; DebugData changes during SEND do not affect bytes or checksum.
- A Reset assertion mid-packet aborts immediately:
  - outputs go to reset values asynchronously;
  - no Done pulse;
  - the partial packet is discarded.
- Busy = 1 exactly in SEND. Done = 1 exactly in DONE. All outputs are registered.

Test Plan:
- Reset, then DebugData with R0=0x1234, R1=0xABCD, R2..R6=0, R7=0x0001; pulse Start with OutReady=1 constantly:
  - 1 cycle later OutValid=1;
  - 18 consecutive bytes A5 12 34 AB CD 00x10 00 01 41;
  - Done pulses 1 cycle after the last transfer; Busy=1 for exactly 18 cycles.
- Same data, OutReady toggling 1/0 each cycle plus a 5-cycle low stall at index 9:
  - identical byte sequence;
  - OutByte stable during stalls;
  - no byte lost or duplicated.
- All registers 0xFFFF: checksum byte 0x00. Change DebugData to 0 right after Start: output still all 0xFF data bytes.
- Pulse Start again at index 4 of a packet: ignored, exactly one 18-byte packet emitted. Then Start during the Done cycle: second packet header appears the next cycle.
- Assert Reset at index 10 while OutValid=1:
  - OutValid, Busy, OutByte go to 0 without waiting for Clk;
  - no Done;
  - after release, a new Start yields a full packet starting with A5.
